// File: rtl/jk_updown_counter_pkg.sv
// jk_pkg: JK command encoding shared by the counter, its cells and the checker.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_cmd_t;

    function automatic logic jk_next(input logic q, input jk_cmd_t cmd);
        return (cmd == JK_TOGGLE) ? ~q :
               (cmd == JK_SET)    ? 1'b1 :
               (cmd == JK_RESET)  ? 1'b0 : q;
    endfunction

endpackage

// File: rtl/jk_updown_counter_if.sv
// jk_updown_counter_if: control inputs and count/status outputs of the counter.
interface jk_updown_counter_if #(parameter int WIDTH = 4);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (output en, up, load, load_val, input count, tc, wrap);
    modport slave  (input en, up, load, load_val, output count, tc, wrap);
endinterface

// File: rtl/jk_updown_counter_cell.sv
// jk_cell: one-bit JK flip-flop with asynchronous active-low clear.
module jk_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);
    logic r_q;

    // Characteristic equation: q+ = j&~q | ~k&q covers hold/reset/set/toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= 1'b0;
        else        r_q <= (j & ~r_q) | (~k & r_q);
    end

    assign q = r_q;
endmodule

// File: rtl/jk_updown_counter.sv
// jk_updown_counter: modulo up/down counter whose state lives in JK cells driven
// by per-bit hold/reset/set/toggle commands derived from the next count.
module jk_updown_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    jk_updown_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
        $error("jk_updown_counter: MODULUS must be in 2..2**WIDTH");
    end

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dn;
    logic [WIDTH-1:0] w_ld;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_diff;
    jk_cmd_t          w_cmd [WIDTH];
    logic             r_wrap;

    // Out-of-range states recover in one edge: up goes to 0, down clamps to MAX.
    assign w_dec  = w_q - 1'b1;
    assign w_inc  = (w_q >= MAX) ? '0 : w_q + 1'b1;
    assign w_dn   = (w_q == '0 || w_dec > MAX) ? MAX : w_dec;
    assign w_ld   = (bus.load_val > MAX) ? MAX : bus.load_val;
    assign w_nxt  = bus.load ? w_ld : bus.en ? (bus.up ? w_inc : w_dn) : w_q;
    assign w_diff = w_q ^ w_nxt;

    always_comb begin
        for (int i = 0; i < WIDTH; i++)
            w_cmd[i] = !w_diff[i] ? JK_HOLD :
                       !bus.load  ? JK_TOGGLE :
                       w_nxt[i]   ? JK_SET : JK_RESET;
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (w_cmd[g][1]),
            .k     (w_cmd[g][0]),
            .q     (w_q[g])
        );
    end

    assign bus.tc = bus.en & ~bus.load &
                    ((bus.up & (w_q == MAX)) | (~bus.up & (w_q == '0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wrap <= 1'b0;
        else        r_wrap <= bus.tc;
    end

    assign bus.count = w_q;
    assign bus.wrap  = r_wrap;

    a_in_range: assert property (@(posedge clk) disable iff (!rst_n) w_q <= MAX)
        else $error("jk_updown_counter: count above MODULUS-1");
endmodule
